decode_ctrl_pipe: RTL and testbench

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

---
 rtl/decode_ctrl_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// Instruction decode stage: turns a 32-bit MIPS-style word into a 14-bit control
// bundle behind a valid/ready pipeline register, and stalls HI/LO users while the multiplier/divider is busy.
module decode_ctrl_pipe #(
  parameter int DIV_CYCLES = 36,
  parameter int MUL_CYCLES = 2,
  parameter int EN_HILO    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] ctrl,
  output logic        hilo_busy
);

  localparam int CNT_W = $clog2(64);

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_MUL  = 2'd1;
  localparam logic [1:0] K_DIV  = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } state_t;

  logic [5:0]       op_s;
  logic [4:0]       rt_s;
  logic [5:0]       funct_s;
  logic [7:0]       main_s;
  logic             hilowrite_s;
  logic             hiloread_s;
  logic             memread_s;
  logic             rawrite_s;
  logic             illegal_s;
  logic             sign_ext_s;
  logic [1:0]       kind_s;
  logic [13:0]      dec_ctrl_s;
  logic [1:0]       dec_kind_s;
  logic             dec_is_hilo_s;
  logic             stall_s;
  logic             accept_s;
  logic             issue_s;

  logic             out_valid_q, out_valid_d;
  logic [13:0]      ctrl_q, ctrl_d;
  logic [1:0]       kind_q, kind_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             hilo_busy_q, hilo_busy_d;
  logic             unused_s;

  assign op_s     = instr[31:26];
  assign rt_s     = instr[20:16];
  assign funct_s  = instr[5:0];
  assign unused_s = ^{instr[25:21], instr[15:6]};

  // Instruction decode into the raw (pre-illegal-masking) control fields.
  always_comb begin
    main_s      = 8'b0000_0000;
    hilowrite_s = 1'b0;
    hiloread_s  = 1'b0;
    memread_s   = 1'b0;
    rawrite_s   = 1'b0;
    illegal_s   = 1'b0;
    kind_s      = K_NONE;
    sign_ext_s  = (op_s[5:2] != 4'b0011);
    case (op_s)
      6'b000000: begin
        case (funct_s)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011: main_s = 8'b1100_0000;
          6'b001000: main_s = 8'b0001_0010;
          6'b001001: main_s = 8'b1101_0011;
          6'b010000, 6'b010010, 6'b010001, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            if (EN_HILO != 0) begin
              main_s      = 8'b1100_0000;
              hiloread_s  = (funct_s[4:3] == 2'b10) && !funct_s[0];
              hilowrite_s = !((funct_s[4:3] == 2'b10) && !funct_s[0]);
              if (funct_s[4:3] == 2'b11) begin
                kind_s = funct_s[1] ? K_DIV : K_MUL;
              end else begin
                kind_s = K_NONE;
              end
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: illegal_s = 1'b1;
        endcase
      end
      // REGIMM branches; the link forms also write $ra
      6'b000001: begin
        case (rt_s)
          5'b00000, 5'b00001, 5'b10000, 5'b10001: begin
            main_s    = {rt_s[4], 6'b001000, rt_s[4]};
            rawrite_s = rt_s[4];
          end
          default: illegal_s = 1'b1;
        endcase
      end
      6'b000010: main_s = 8'b0000_0010;
      6'b000011: begin
        main_s    = 8'b1000_0011;
        rawrite_s = 1'b1;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: main_s = 8'b0001_0000;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: main_s = 8'b1010_0000;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        main_s    = 8'b1010_0100;
        memread_s = 1'b1;
      end
      6'b101000, 6'b101001, 6'b101011: main_s = 8'b0010_1000;
      default: illegal_s = 1'b1;
    endcase
  end

  // Illegal words collapse to a bundle carrying only the illegal flag.
  always_comb begin
    if (illegal_s) begin
      dec_ctrl_s = 14'b00_0000_0000_0001;
      dec_kind_s = K_NONE;
    end else begin
      dec_ctrl_s = {main_s, sign_ext_s, hilowrite_s, hiloread_s, memread_s, rawrite_s, 1'b0};
      dec_kind_s = kind_s;
    end
  end

  assign dec_is_hilo_s = dec_ctrl_s[4] | dec_ctrl_s[3];
  assign stall_s  = in_valid && dec_is_hilo_s &&
                    (hilo_busy_q || (out_valid_q && (kind_q != K_NONE)));
  assign in_ready = (!out_valid_q || out_ready) && !stall_s;
  assign accept_s = in_valid && in_ready;
  assign issue_s  = out_valid_q && out_ready;

  // Output register next-state: load on accept, drain on consume, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    kind_d      = kind_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl_s;
      kind_d      = dec_kind_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      kind_d      = K_NONE;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // HI/LO occupancy FSM; a fresh mult/div issue reloads ahead of the countdown.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    if (issue_s && (kind_q == K_MUL)) begin
      state_d    = MUL_BUSY;
      busy_cnt_d = CNT_W'(MUL_CYCLES);
    end else if (issue_s && (kind_q == K_DIV)) begin
      state_d    = DIV_BUSY;
      busy_cnt_d = CNT_W'(DIV_CYCLES);
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = IDLE;
          busy_cnt_d = {CNT_W{1'b0}};
        end
        MUL_BUSY, DIV_BUSY: begin
          if (busy_cnt_q <= CNT_W'(1)) begin
            state_d    = IDLE;
            busy_cnt_d = {CNT_W{1'b0}};
          end else begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          busy_cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end
    hilo_busy_d = (state_d != IDLE);
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= 14'b0;
      kind_q      <= K_NONE;
      state_q     <= IDLE;
      busy_cnt_q  <= {CNT_W{1'b0}};
      hilo_busy_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      kind_q      <= kind_d;
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      hilo_busy_q <= hilo_busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ctrl      = ctrl_q;
  assign hilo_busy = hilo_busy_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode table vectors, HI/LO hazard stalls,
// backpressure, EN_HILO=0 and asynchronous reset mid-countdown.
module tb_decode_ctrl_pipe;

  logic        clk;
  logic        resetn;
  logic [31:0] instr;
  logic        out_ready;
  logic        iv_a, iv_b, iv_c;
  logic        ir_a, ir_b, ir_c;
  logic        ov_a, ov_b, ov_c;
  logic [13:0] ctrl_a, ctrl_b, ctrl_c;
  logic        busy_a, busy_b, busy_c;

  int n_chk  = 0;
  int n_fail = 0;

  decode_ctrl_pipe #(.DIV_CYCLES(4), .MUL_CYCLES(2), .EN_HILO(1)) dut_a (
    .clk(clk), .resetn(resetn), .in_valid(iv_a), .in_ready(ir_a), .instr(instr),
    .out_valid(ov_a), .out_ready(out_ready), .ctrl(ctrl_a), .hilo_busy(busy_a));

  decode_ctrl_pipe dut_b (
    .clk(clk), .resetn(resetn), .in_valid(iv_b), .in_ready(ir_b), .instr(instr),
    .out_valid(ov_b), .out_ready(out_ready), .ctrl(ctrl_b), .hilo_busy(busy_b));

  decode_ctrl_pipe #(.EN_HILO(0)) dut_c (
    .clk(clk), .resetn(resetn), .in_valid(iv_c), .in_ready(ir_c), .instr(instr),
    .out_valid(ov_c), .out_ready(out_ready), .ctrl(ctrl_c), .hilo_busy(busy_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] ins;
    logic [13:0] exp;
  } vec_t;

  localparam logic [31:0] I_ADDU = 32'h0109_5021;
  localparam logic [31:0] I_ORI  = 32'h350A_00FF;
  localparam logic [31:0] I_DIV  = 32'h0109_001A;
  localparam logic [31:0] I_MULT = 32'h0109_0018;
  localparam logic [31:0] I_MFLO = 32'h0000_5012;
  localparam logic [31:0] I_MFHI = 32'h0000_5010;
  localparam logic [31:0] I_MTHI = 32'h0100_0011;

  localparam logic [13:0] C_R     = 14'b11000000_100000;
  localparam logic [13:0] C_ORI   = 14'b10100000_000000;
  localparam logic [13:0] C_HW    = 14'b11000000_110000;
  localparam logic [13:0] C_HR    = 14'b11000000_101000;
  localparam logic [13:0] C_ILL   = 14'b00000000_000001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First op goes to the output register, second (a HI/LO op) must wait.
  task automatic hazard(input string nm, input logic [31:0] first, input logic [31:0] second,
                        input logic [13:0] first_c, input logic [13:0] second_c,
                        input int exp_stall, input int exp_busy);
    int n_stall = 0;
    int n_busy  = 0;
    logic got   = 1'b0;
    logic busy_at = 1'b1;
    instr = first; iv_a = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_first_ready"}, ir_a, 1'b1);
    tick();
    instr = second;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (c == 0) chk({nm, "_first_ctrl"}, ctrl_a, first_c);
      if (ir_a) begin
        got = 1'b1;
        busy_at = busy_a;
      end else begin
        n_stall++;
        if (busy_a) n_busy++;
        tick();
      end
    end
    chk({nm, "_accepted"}, got, 1'b1);
    chk({nm, "_stall_cycles"}, n_stall, exp_stall);
    chk({nm, "_busy_cycles"}, n_busy, exp_busy);
    chk({nm, "_busy_at_accept"}, busy_at, 1'b0);
    tick();
    iv_a = 1'b0;
    @(negedge clk);
    chk({nm, "_second_ctrl"}, ctrl_a, second_c);
    chk({nm, "_second_valid"}, ov_a, 1'b1);
    tick();
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back('{32'h8C08_0004, 14'b10100100_100100}); // LW
    vecs.push_back('{32'hAC08_0004, 14'b00101000_100000}); // SW
    vecs.push_back('{32'h1109_0003, 14'b00010000_100000}); // BEQ
    vecs.push_back('{I_ADDU,        C_R});
    vecs.push_back('{I_ORI,         C_ORI});
    vecs.push_back('{32'h3C0A_1234, 14'b10100000_000000}); // LUI
    vecs.push_back('{32'h390A_0005, 14'b10100000_000000}); // XORI
    vecs.push_back('{32'h210A_0001, 14'b10100000_100000}); // ADDI
    vecs.push_back('{32'h2D0A_0005, 14'b10100000_100000}); // SLTIU
    vecs.push_back('{32'h0800_0010, 14'b00000010_100000}); // J
    vecs.push_back('{32'h0C00_0010, 14'b10000011_100010}); // JAL
    vecs.push_back('{32'h0100_0008, 14'b00010010_100000}); // JR
    vecs.push_back('{32'h0100_F809, 14'b11010011_100000}); // JALR
    vecs.push_back('{32'h0511_0004, 14'b10010001_100010}); // BGEZAL
    vecs.push_back('{32'h0510_0004, 14'b10010001_100010}); // BLTZAL
    vecs.push_back('{32'h0500_0004, 14'b00010000_100000}); // BLTZ
    vecs.push_back('{32'h0502_0004, C_ILL});               // REGIMM rt=00010
    vecs.push_back('{I_MFHI,        C_HR});
    vecs.push_back('{32'h0100_0013, C_HW});                // MTLO
    vecs.push_back('{32'h4000_0000, C_ILL});               // undefined op
    vecs.push_back('{32'h0000_0001, C_ILL});               // undefined funct
    vecs.push_back('{32'h9109_0000, 14'b10100100_100100}); // LBU
    vecs.push_back('{32'hA008_0000, 14'b00101000_100000}); // SB
    vecs.push_back('{32'h1D00_0003, 14'b00010000_100000}); // BGTZ

    resetn = 1'b1; instr = I_ADDU; out_ready = 1'b1;
    iv_a = 1'b1; iv_b = 1'b0; iv_c = 1'b0;
    #2 resetn = 1'b0;

    // Reset values, and first accept on the first edge after release.
    @(negedge clk);
    chk("rst_out_valid", ov_a, 1'b0);
    chk("rst_ctrl", ctrl_a, 14'b0);
    chk("rst_hilo_busy", busy_a, 1'b0);
    chk("rst_in_ready", ir_a, 1'b1);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("rel_no_edge_valid", ov_a, 1'b0);
    tick();
    iv_a = 1'b0;
    @(negedge clk);
    chk("first_accept_valid", ov_a, 1'b1);
    chk("first_accept_ctrl", ctrl_a, C_R);
    tick();

    // Back-to-back decode table stream.
    for (int i = 0; i < vecs.size(); i++) begin
      instr = vecs[i].ins;
      iv_a = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d_ctrl", i - 1), ctrl_a, vecs[i-1].exp);
        chk($sformatf("vec%0d_valid", i - 1), ov_a, 1'b1);
      end
      chk($sformatf("vec%0d_ready", i), ir_a, 1'b1);
      tick();
    end
    iv_a = 1'b0;
    @(negedge clk);
    chk("vec_last_ctrl", ctrl_a, vecs[vecs.size()-1].exp);
    chk("vec_last_valid", ov_a, 1'b1);
    tick();
    @(negedge clk);
    chk("drain_valid_clear", ov_a, 1'b0);
    tick();

    hazard("div_mflo", I_DIV, I_MFLO, C_HW, C_HR, 5, 4);
    hazard("mult_mthi", I_MULT, I_MTHI, C_HW, C_HW, 3, 2);

    // Backpressure with ORI held in the output register.
    instr = I_ORI; iv_a = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; instr = I_ADDU;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ctrl", c), ctrl_a, C_ORI);
      chk($sformatf("bp%0d_ready", c), ir_a, 1'b0);
      chk($sformatf("bp%0d_valid", c), ov_a, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ir_a, 1'b1);
    tick();
    iv_a = 1'b0;
    @(negedge clk);
    chk("bp_next_ctrl", ctrl_a, C_R);
    tick();

    // HI/LO disabled: MULT and MFHI both decode illegal, FSM never leaves IDLE.
    instr = I_MULT; iv_c = 1'b1;
    @(negedge clk);
    chk("nohilo_mult_ready", ir_c, 1'b1);
    tick();
    instr = I_MFHI;
    @(negedge clk);
    chk("nohilo_mult_ctrl", ctrl_c, C_ILL);
    chk("nohilo_mfhi_ready", ir_c, 1'b1);
    tick();
    iv_c = 1'b0;
    @(negedge clk);
    chk("nohilo_mfhi_ctrl", ctrl_c, C_ILL);
    chk("nohilo_busy", busy_c, 1'b0);
    tick();
    @(negedge clk);
    chk("nohilo_busy_late", busy_c, 1'b0);
    tick();

    // DIV countdown on the default-parameter instance, reset at busy_cnt=20.
    instr = I_DIV; iv_b = 1'b1; out_ready = 1'b1;
    tick();
    iv_b = 1'b0;
    tick();
    chk("divb_busy_start", busy_b, 1'b1);
    repeat (15) tick();
    instr = I_ADDU; iv_b = 1'b1;
    tick();
    iv_b = 1'b0; out_ready = 1'b0;
    chk("divb_busy_mid", busy_b, 1'b1);
    chk("divb_valid_mid", ov_b, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", ov_b, 1'b0);
    chk("async_rst_busy", busy_b, 1'b0);
    chk("async_rst_ctrl", ctrl_b, 14'b0);
    chk("async_rst_ready", ir_b, 1'b1);
    @(posedge clk);
    #2 resetn = 1'b1;
    instr = I_ADDU; iv_b = 1'b1; out_ready = 1'b1;
    tick();
    iv_b = 1'b0;
    chk("post_rst_valid", ov_b, 1'b1);
    chk("post_rst_ctrl", ctrl_b, C_R);
    chk("post_rst_busy", busy_b, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
